// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Latency: n/a (types and combinational helper functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, onehot() index decoder, rr_pick() reference pick.
package rr_arb_pkg;

   // Upper bound on requester count for the width-generic helpers below.
   localparam int MAX_GN = 64;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GNT  = 1'b1
   } state_t;

   // Decode an index into a one-hot vector; out-of-range indices give zero.
   function automatic logic [MAX_GN-1:0] onehot(input int idx, input int gn);
      logic [MAX_GN-1:0] v;
      v = '0;
      if (idx >= 0 && idx < gn && idx < MAX_GN) v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: scan from ptr upwards with wrap-around.
   // Returns {found, idx[5:0]}.
   function automatic logic [6:0] rr_pick(input logic [MAX_GN-1:0] req,
                                          input int ptr, input int gn);
      logic [6:0] r;
      int         j;
      r = '0;
      // Walk backwards so the candidate closest to ptr is assigned last.
      for (int k = gn - 1; k >= 0; k--) begin
         j = (ptr + k) % gn;
         if (req[j]) r = {1'b1, 6'(j)};
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Round-robin winner select: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; output follows inputs in the same cycle.
// Ports: req (request vector), ptr (highest-priority index),
//        found (any request), idx (winner index), oh (winner one-hot, zero if none).
module rr_pick_comb
   import rr_arb_pkg::*;
#(
   parameter int GN = 2,
   parameter int IW = $clog2(GN)
) (
   input  logic [GN-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx,
   output logic [GN-1:0] oh
);

   localparam int PW = $clog2(2 * GN);

   logic [2*GN-1:0] dbl;
   logic [PW-1:0]   pos;

   // Lower copy has the bits below ptr masked off; the upper copy is the
   // unmasked wrap-around, so the lowest set bit overall is the RR winner.
   always_comb begin
      dbl = {req, req};
      for (int i = 0; i < GN; i++) begin
         if (i < int'(ptr)) dbl[i] = 1'b0;
      end

      found = |dbl;

      pos = '0;
      for (int i = 2 * GN - 1; i >= 0; i--) begin
         if (dbl[i]) pos = PW'(i);
      end

      if (pos >= PW'(GN)) idx = IW'(pos - PW'(GN));
      else                idx = IW'(pos);

      oh = '0;
      for (int i = 0; i < GN; i++) begin
         oh[i] = found && (int'(idx) == i);
      end
   end

endmodule

// File: rtl/rr_grant_arb.sv
// Round-robin arbiter producing a registered one-hot select enable, held per burst.
// Latency: grant 1 cycle after request; back-to-back re-grant on completion, no bubble.
// Backpressure: grant held until Ack_In on the last beat or MAXB beats (Err_Ovf pulse).
// Ports: Clk, Rst (sync active-high), Req_In/Lst_In per requester, Ack_In beat accept,
//        Gnt_En one-hot grant, Gnt_Vld = |Gnt_En, Gnt_Id grant index, Err_Ovf overflow pulse.
module rr_grant_arb
   import rr_arb_pkg::*;
#(
   parameter int GN   = 2,
   parameter int MAXB = 16,
   parameter int IW   = $clog2(GN)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic [GN-1:0] Req_In,
   input  logic [GN-1:0] Lst_In,
   input  logic          Ack_In,
   output logic [GN-1:0] Gnt_En,
   output logic          Gnt_Vld,
   output logic [IW-1:0] Gnt_Id,
   output logic          Err_Ovf
);

   localparam int BW = $clog2(MAXB + 1);

   state_t        state;
   logic [IW-1:0] ptr;
   logic [BW-1:0] beat_cnt;

   logic [IW-1:0] ptr_inc;
   logic [IW-1:0] pick_ptr;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [GN-1:0] pick_oh;
   logic          lst;
   logic          ovf;
   logic          done;

   // Pointer just past the current grant; becomes Ptr on completion.
   assign ptr_inc = (Gnt_Id == IW'(GN - 1)) ? '0 : Gnt_Id + IW'(1);

   // While granted, the pick is only consumed at completion, so it is
   // computed against the post-completion pointer to allow back-to-back grants.
   assign pick_ptr = (state == S_GNT) ? ptr_inc : ptr;

   assign lst  = Lst_In[Gnt_Id];
   assign ovf  = (beat_cnt == BW'(MAXB - 1));
   assign done = lst | ovf;

   rr_pick_comb #(
      .GN (GN),
      .IW (IW)
   ) u_pick (
      .req   (Req_In),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx),
      .oh    (pick_oh)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= S_IDLE;
         ptr      <= '0;
         beat_cnt <= '0;
         Gnt_En   <= '0;
         Gnt_Vld  <= 1'b0;
         Gnt_Id   <= '0;
         Err_Ovf  <= 1'b0;
      end else begin
         Err_Ovf <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  state    <= S_GNT;
                  Gnt_En   <= pick_oh;
                  Gnt_Vld  <= 1'b1;
                  Gnt_Id   <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            S_GNT: begin
               if (Ack_In) begin
                  if (done) begin
                     ptr      <= ptr_inc;
                     beat_cnt <= '0;
                     // A last beat landing on the MAXB-th beat is a clean finish.
                     Err_Ovf  <= ovf & ~lst;
                     if (pick_found) begin
                        Gnt_En <= pick_oh;
                        Gnt_Id <= pick_idx;
                     end else begin
                        state   <= S_IDLE;
                        Gnt_En  <= '0;
                        Gnt_Vld <= 1'b0;
                        Gnt_Id  <= '0;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               Gnt_En  <= '0;
               Gnt_Vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_grant_arb.sv
module tb_rr_grant_arb;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] lst;
   logic       ack;
   logic [3:0] gnt_en;
   logic       gnt_vld;
   logic [1:0] gnt_id;
   logic       err_ovf;

   int checks   = 0;
   int failures = 0;
   bit mon_on   = 1'b0;

   rr_grant_arb #(
      .GN   (4),
      .MAXB (4)
   ) dut (
      .Clk     (clk),
      .Rst     (rst),
      .Req_In  (req),
      .Lst_In  (lst),
      .Ack_In  (ack),
      .Gnt_En  (gnt_en),
      .Gnt_Vld (gnt_vld),
      .Gnt_Id  (gnt_id),
      .Err_Ovf (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Continuous invariant: one-hot-or-zero grant, valid tracks it.
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (!$onehot0(gnt_en) || (gnt_vld !== (|gnt_en))) begin
            $display("FAIL onehot_vld gnt_en=%b gnt_vld=%b", gnt_en, gnt_vld);
            failures++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; lst = '0; ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req = 4'($urandom); lst = 4'($urandom); ack = 1'($urandom);
         tick();
         checks++;
         if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || err_ovf !== 1'b0) begin
            $display("FAIL reset_hold cyc=%0d en=%b vld=%b id=%0d ovf=%b want 0000/0/0/0",
                     i, gnt_en, gnt_vld, gnt_id, err_ovf);
            failures++;
         end
      end
      mon_on = 1'b1;
      rst = 1'b0; req = '0; lst = '0; ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || err_ovf !== 1'b0) begin
            $display("FAIL post_reset_idle cyc=%0d en=%b vld=%b id=%0d ovf=%b want 0000/0/0/0",
                     i, gnt_en, gnt_vld, gnt_id, err_ovf);
            failures++;
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      tick();
      checks++;
      if (gnt_en !== 4'b0001 || gnt_vld !== 1'b1 || gnt_id !== 2'd0) begin
         $display("FAIL single_grant en=%b vld=%b id=%0d want 0001/1/0", gnt_en, gnt_vld, gnt_id);
         failures++;
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gnt_en !== 4'b0001 || gnt_id !== 2'd0) begin
         $display("FAIL single_hold_no_req en=%b id=%0d want 0001/0", gnt_en, gnt_id);
         failures++;
      end
      ack = 1'b1; lst = 4'b0001;
      tick();
      checks++;
      if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || err_ovf !== 1'b0) begin
         $display("FAIL single_release en=%b vld=%b ovf=%b want 0000/0/0", gnt_en, gnt_vld, err_ovf);
         failures++;
      end
      ack = 1'b0; lst = '0;
   endtask

   task automatic test_fairness();
      logic [3:0] exp_en [5];
      logic [1:0] exp_id [5];
      exp_en = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req = 4'b1111; ack = 1'b1; lst = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt_en !== exp_en[i] || gnt_id !== exp_id[i] || err_ovf !== 1'b0) begin
            $display("FAIL fairness cyc=%0d en=%b id=%0d ovf=%b want %b/%0d/0",
                     i, gnt_en, gnt_id, err_ovf, exp_en[i], exp_id[i]);
            failures++;
         end
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0) begin
         $display("FAIL fairness_drain en=%b vld=%b want 0000/0", gnt_en, gnt_vld);
         failures++;
      end
      ack = 1'b0; lst = '0;
   endtask

   // Follows test_fairness: pointer is now 1.
   task automatic test_burst_hold();
      req = 4'b0010;
      tick();
      checks++;
      if (gnt_en !== 4'b0010 || gnt_id !== 2'd1) begin
         $display("FAIL burst_grant en=%b id=%0d want 0010/1", gnt_en, gnt_id);
         failures++;
      end
      // Beat 1: others flag last, the granted one does not.
      req = 4'b1111; ack = 1'b1; lst = 4'b1101;
      tick();
      checks++;
      if (gnt_en !== 4'b0010 || err_ovf !== 1'b0) begin
         $display("FAIL burst_beat1 en=%b ovf=%b want 0010/0", gnt_en, err_ovf);
         failures++;
      end
      // Beat 2: granted requester drops its request.
      req = 4'b1101;
      tick();
      checks++;
      if (gnt_en !== 4'b0010 || err_ovf !== 1'b0) begin
         $display("FAIL burst_beat2 en=%b ovf=%b want 0010/0", gnt_en, err_ovf);
         failures++;
      end
      req = 4'b1111; lst = 4'b0010;
      tick();
      checks++;
      if (gnt_en !== 4'b0100 || gnt_id !== 2'd2 || err_ovf !== 1'b0) begin
         $display("FAIL burst_last en=%b id=%0d ovf=%b want 0100/2/0", gnt_en, gnt_id, err_ovf);
         failures++;
      end
      ack = 1'b0; lst = '0; req = '0;
      tick();
      checks++;
      if (gnt_en !== 4'b0100 || err_ovf !== 1'b0) begin
         $display("FAIL burst_no_ack_hold en=%b ovf=%b want 0100/0", gnt_en, err_ovf);
         failures++;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      req = 4'b0001;
      tick();
      req = 4'b0011; ack = 1'b1; lst = 4'b0000;
      for (int b = 0; b < 3; b++) begin
         tick();
         checks++;
         if (gnt_en !== 4'b0001 || err_ovf !== 1'b0) begin
            $display("FAIL ovf_hold beat=%0d en=%b ovf=%b want 0001/0", b + 1, gnt_en, err_ovf);
            failures++;
         end
      end
      tick();
      checks++;
      if (gnt_en !== 4'b0010 || gnt_id !== 2'd1 || err_ovf !== 1'b1) begin
         $display("FAIL ovf_release en=%b id=%0d ovf=%b want 0010/1/1", gnt_en, gnt_id, err_ovf);
         failures++;
      end
      ack = 1'b0;
      tick();
      checks++;
      if (gnt_en !== 4'b0010 || err_ovf !== 1'b0) begin
         $display("FAIL ovf_pulse_width en=%b ovf=%b want 0010/0", gnt_en, err_ovf);
         failures++;
      end
      // Last beat coinciding with the MAXB-th beat: clean completion.
      ack = 1'b1;
      for (int b = 0; b < 3; b++) begin
         tick();
         checks++;
         if (gnt_en !== 4'b0010 || err_ovf !== 1'b0) begin
            $display("FAIL lst_ovf_hold beat=%0d en=%b ovf=%b want 0010/0", b + 1, gnt_en, err_ovf);
            failures++;
         end
      end
      lst = 4'b0010;
      tick();
      checks++;
      if (gnt_en !== 4'b0001 || gnt_id !== 2'd0 || err_ovf !== 1'b0) begin
         $display("FAIL lst_ovf_same_beat en=%b id=%0d ovf=%b want 0001/0/0", gnt_en, gnt_id, err_ovf);
         failures++;
      end
      ack = 1'b0; lst = '0; req = '0;
   endtask

   task automatic test_ack_idle();
      do_reset();
      ack = 1'b1; lst = 4'b1111;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || err_ovf !== 1'b0) begin
            $display("FAIL ack_idle cyc=%0d en=%b vld=%b ovf=%b want 0000/0/0", i, gnt_en, gnt_vld, err_ovf);
            failures++;
         end
      end
      req = 4'b1000; ack = 1'b0; lst = '0;
      tick();
      checks++;
      if (gnt_en !== 4'b1000 || gnt_id !== 2'd3) begin
         $display("FAIL ack_idle_grant en=%b id=%0d want 1000/3", gnt_en, gnt_id);
         failures++;
      end
      // Idle acks must not have advanced the beat counter.
      ack = 1'b1;
      for (int b = 0; b < 3; b++) begin
         tick();
         checks++;
         if (gnt_en !== 4'b1000 || err_ovf !== 1'b0) begin
            $display("FAIL ack_idle_beats beat=%0d en=%b ovf=%b want 1000/0", b + 1, gnt_en, err_ovf);
            failures++;
         end
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || err_ovf !== 1'b1) begin
         $display("FAIL ovf_to_idle en=%b vld=%b ovf=%b want 0000/0/1", gnt_en, gnt_vld, err_ovf);
         failures++;
      end
      ack = 1'b0;
      tick();
      checks++;
      if (gnt_en !== 4'b0000 || err_ovf !== 1'b0) begin
         $display("FAIL ovf_to_idle_after en=%b ovf=%b want 0000/0", gnt_en, err_ovf);
         failures++;
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0001;
      tick();
      // Complete requester 0 so the pointer moves to 1, then grant 2 back-to-back.
      ack = 1'b1; lst = 4'b0001; req = 4'b0100;
      tick();
      checks++;
      if (gnt_en !== 4'b0100 || gnt_id !== 2'd2) begin
         $display("FAIL mid_b2b_grant en=%b id=%0d want 0100/2", gnt_en, gnt_id);
         failures++;
      end
      lst = 4'b0000;
      tick();
      tick();
      checks++;
      if (gnt_en !== 4'b0100 || err_ovf !== 1'b0) begin
         $display("FAIL mid_two_beats en=%b ovf=%b want 0100/0", gnt_en, err_ovf);
         failures++;
      end
      rst = 1'b1; req = 4'b1111; ack = 1'b1;
      tick();
      checks++;
      if (gnt_en !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== 2'd0 || err_ovf !== 1'b0) begin
         $display("FAIL mid_reset en=%b vld=%b id=%0d ovf=%b want 0000/0/0/0",
                  gnt_en, gnt_vld, gnt_id, err_ovf);
         failures++;
      end
      rst = 1'b0; ack = 1'b0;
      tick();
      checks++;
      if (gnt_en !== 4'b0001 || gnt_id !== 2'd0) begin
         $display("FAIL mid_reset_ptr en=%b id=%0d want 0001/0", gnt_en, gnt_id);
         failures++;
      end
      req = '0;
   endtask

   initial begin
      rst = 1'b1; req = '0; lst = '0; ack = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_burst_hold();
      test_overflow();
      test_ack_idle();
      test_reset_mid_burst();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
